rtc_bus_scheduler: RTL and testbench
====================================

# rtc_bus_scheduler

Sequences every access to the RTC over the shared multiplexed `DIR_DATO` bus and generates `CS`, `RD`, `WR` and `A_D`. It arbitrates between two requesters: a periodic time/date read-back, and PicoBlaze-initiated write bursts for time, date or timer. Each burst runs to completion as an atomic sequence of address/data accesses. Read bytes are presented to the datapath tagged with their RTC address.

## Interface
- `T_PH`, 9: cycles per bus phase; legal range is ≥1.
- `reloj`  in  1  system clock; all logic is on the rising edge.
- `resetM`  in  1  asynchronous, active-low reset.
- `tick_lectura`  in  1  one-cycle pulse that requests a read burst.
- `req_esc`  in  1  write request, level; held until `ack_esc`.
- `grupo_esc`  in  2  selects the write group: 0 = hora, 1 = fecha, 2 = crono, 3 = invalid.
- `dato_esc0`, `dato_esc1`, `dato_esc2`  in  8 each  bytes for group base +0, +1, +2; sampled at grant.
- `ack_esc`  out  1  one-cycle pulse when a write burst completes.
- `dato_leido`  out  8  captured read byte.
- `dir_leido`  out  8  RTC address of `dato_leido`.
- `valido_leido`  out  1  one-cycle pulse for each captured byte.
- `ocupado`  out  1  high while a burst is in progress.
- `CS`, `RD`, `WR`  out  1 each  active-low RTC strobes.
- `A_D`  out  1  low = address phase, high = data phase.
- `DIR_DATO`  inout  8  multiplexed address/data bus; Hi-Z unless this block is driving it.

## Operation
- Group bases:
  - hora 0x21: seg, min, hora.
  - fecha 0x24: dia, mes, ano.
  - crono 0x41: seg, min, hora.
- Read burst, 7 accesses:
  - Write 0x00 to 0xF0 (transfer command).
  - Read 0x21, 0x22, 0x23, 0x24, 0x25, 0x26.
- Write burst, 4 accesses:
  - Write `dato_esc0..2` to base+0..2.
  - Write 0x00 to 0xF1 (commit command).
- Access FSM states: IDLE → ADDR → GAP1 → DATA → GAP2, then back to ADDR (more accesses) or IDLE (last access). Each non-IDLE state lasts exactly `T_PH` cycles.
  - ADDR: `CS`=0, `WR`=0, `A_D`=0; address driven on `DIR_DATO`.
  - GAP1, GAP2: `CS`, `RD`, `WR` = 1; `A_D` = 1; bus Hi-Z.
  - DATA, write access: `CS`=0, `WR`=0, `A_D`=1; data driven.
  - DATA, read access: `CS`=0, `RD`=0, `A_D`=1; bus Hi-Z.
- Read capture: `DIR_DATO` is captured on the last DATA cycle. `dato_leido` and `dir_leido` update and `valido_leido` pulses on the next cycle. Outputs hold until the next capture.
- Pending read flag:
  - Set by `tick_lectura` at any time.
  - Repeated ticks while pending merge into one request.
  - Cleared when its read burst is granted.
- Arbitration in IDLE: a pending write has priority over a pending read. A burst is never preempted.
- Write data and group are latched at grant; later changes are ignored.
- `grupo_esc`=3 at grant: no bus activity, `ack_esc` pulses the next cycle, FSM stays IDLE.
- `req_esc` still high in the cycle after `ack_esc` counts as a new request.
- Phase counter is ⌈log2 T_PH⌉ bits wide. Access index is 3 bits.

## Timing
- Reset values:
  - `CS`, `RD`, `WR`, `A_D` = 1.
  - `DIR_DATO` Hi-Z.
  - `ack_esc`, `valido_leido`, `ocupado` = 0.
  - `dato_leido`, `dir_leido` = 0x00.
  - Pending flag clear; FSM in IDLE.
- Reset mid-burst: all strobes return high immediately and asynchronously. The burst is abandoned and there is no `ack_esc`.
- Grant latency: a request visible in IDLE at edge n gives `CS` low from n+1. `ocupado` rises at n+1.
- Burst length: 4·`T_PH` cycles per access. Read burst = 28·`T_PH`; write burst = 16·`T_PH`.
- `ack_esc` pulses and `ocupado` falls in the first IDLE cycle after the final GAP2.
- Back-to-back bursts: the next grant is evaluated in that IDLE cycle. There is a minimum of one IDLE cycle between bursts.
- Bus turnaround: `DIR_DATO` is released on the same edge that the strobes rise. It is never driven during a read DATA phase.

## Test plan
- Reset: with `resetM`=0, all strobes = 1, bus Z, `ocupado`=0. Releasing reset with no requests → no strobe activity for 1000 cycles.
- Read burst, `T_PH`=2, RTC model returning address+0x10:
  - `CS` low one cycle after the tick.
  - 7 accesses over 56 cycles.
  - 6 `valido_leido` pulses, (`dir_leido`, `dato_leido`) = (0x21, 0x31) … (0x26, 0x36).
  - `ack_esc` stays 0.
- Write hora, `dato_esc` = 0x45, 0x30, 0x12:
  - Bus shows writes 0x21←0x45, 0x22←0x30, 0x23←0x12, 0xF1←0x00.
  - `ack_esc` pulses once, 32 cycles after grant.
- Simultaneous `tick_lectura` and `req_esc` (group 1) → write burst to 0x24–0x26 first, then the read burst, with one IDLE cycle between them.
- Three ticks during a write burst → exactly one read burst follows. `grupo_esc`=3 → `ack_esc` one cycle after grant, no `CS` activity.
- Assert `resetM` in the 3rd read access DATA phase → strobes high immediately, no further `valido_leido`. After release, the next tick runs a full 7-access burst.

Source files
------------

// File: rtl/rtc_bus_scheduler_if.sv
// ---------------------------------------------------------------------------
// rtc_bus_scheduler_if
//
// Groups the request/response handshake and the RTC strobes of the RTC bus
// scheduler. The multiplexed DIR_DATO pad stays a plain inout port on the
// scheduler so that the tristate stays at the pin boundary.
//
// Signals:
//   tick_lectura            periodic read-back request (one-cycle pulse)
//   req_esc / ack_esc       write burst request (level) and completion pulse
//   grupo_esc               write group: 0 hora, 1 fecha, 2 crono, 3 invalid
//   dato_esc0..2            bytes for group base +0, +1, +2
//   dato_leido / dir_leido  captured read byte and its RTC address
//   valido_leido            one-cycle pulse per captured byte
//   ocupado                 high while a burst is in progress
//   CS, RD, WR              active-low RTC strobes
//   A_D                     low = address phase, high = data phase
//
// Modports:
//   master  the scheduler (drives the strobes and the read-back outputs)
//   slave   the requester/datapath side
// ---------------------------------------------------------------------------
interface rtc_bus_scheduler_if;
    logic       tick_lectura;
    logic       req_esc;
    logic [1:0] grupo_esc;
    logic [7:0] dato_esc0;
    logic [7:0] dato_esc1;
    logic [7:0] dato_esc2;
    logic       ack_esc;
    logic [7:0] dato_leido;
    logic [7:0] dir_leido;
    logic       valido_leido;
    logic       ocupado;
    logic       CS;
    logic       RD;
    logic       WR;
    logic       A_D;

    modport master (
        input  tick_lectura, req_esc, grupo_esc, dato_esc0, dato_esc1, dato_esc2,
        output ack_esc, dato_leido, dir_leido, valido_leido, ocupado,
        output CS, RD, WR, A_D
    );

    modport slave (
        output tick_lectura, req_esc, grupo_esc, dato_esc0, dato_esc1, dato_esc2,
        input  ack_esc, dato_leido, dir_leido, valido_leido, ocupado,
        input  CS, RD, WR, A_D
    );
endinterface

// File: rtl/rtc_bus_scheduler.sv
// ---------------------------------------------------------------------------
// rtc_bus_scheduler
//
// Sequences every access to the RTC over the shared multiplexed DIR_DATO
// bus. Two requesters are arbitrated in IDLE: a pending periodic read-back
// (transfer command to 0xF0 followed by reads of 0x21..0x26) and a
// PicoBlaze write burst (three bytes to the group base followed by a commit
// command to 0xF1). A write has priority; a burst, once granted, always runs
// to completion. Each access is ADDR, GAP1, DATA, GAP2, each T_PH cycles.
//
// Ports:
//   reloj     system clock, rising edge
//   resetM    asynchronous active-low reset
//   bus       rtc_bus_scheduler_if.master (handshake, read-back, strobes)
//   DIR_DATO  multiplexed address/data bus, Hi-Z unless driven here
//
// Parameter:
//   T_PH      cycles per bus phase (>= 1)
// ---------------------------------------------------------------------------
module rtc_bus_scheduler #(
    parameter int T_PH = 9
) (
    input  logic                 reloj,
    input  logic                 resetM,
    rtc_bus_scheduler_if.master  bus,
    inout  wire  [7:0]           DIR_DATO
);

    localparam int            PW      = (T_PH > 1) ? $clog2(T_PH) : 1;
    localparam logic [PW-1:0] PH_LAST = PW'(T_PH - 1);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        GAP1,
        DATA,
        GAP2
    } state_t;

    state_t          state;
    logic [PW-1:0]   phase;
    logic [2:0]      idx;
    logic            is_read;
    logic [1:0]      grp;
    logic [2:0][7:0] wdat;
    logic            pend;

    logic            drv_en;
    logic [7:0]      drv_val;
    logic            cs_q;
    logic            rd_q;
    logic            wr_q;
    logic            ad_q;
    logic            ack_q;
    logic            val_q;
    logic            ocu_q;
    logic [7:0]      dato_q;
    logic [7:0]      dir_q;

    // RTC address of access i of a burst. Read bursts open with the transfer
    // command at 0xF0; write bursts close with the commit command at 0xF1.
    function automatic logic [7:0] acc_addr(input logic       rd_burst,
                                            input logic [1:0] g,
                                            input logic [2:0] i);
        logic [7:0] base;
        logic [7:0] res;
        case (g)
            2'd0:    base = 8'h21;
            2'd1:    base = 8'h24;
            default: base = 8'h41;
        endcase
        if (rd_burst) begin
            res = (i == 3'd0) ? 8'hF0 : (8'h20 + {5'd0, i});
        end else begin
            res = (i == 3'd3) ? 8'hF1 : (base + {5'd0, i});
        end
        return res;
    endfunction

    // Write data of access i of a write burst; the commit command carries 0x00.
    function automatic logic [7:0] acc_data(input logic [2:0]      i,
                                            input logic [2:0][7:0] d);
        logic [7:0] res;
        case (i)
            3'd0:    res = d[0];
            3'd1:    res = d[1];
            3'd2:    res = d[2];
            default: res = 8'h00;
        endcase
        return res;
    endfunction

    assign DIR_DATO         = drv_en ? drv_val : 8'hzz;
    assign bus.CS           = cs_q;
    assign bus.RD           = rd_q;
    assign bus.WR           = wr_q;
    assign bus.A_D          = ad_q;
    assign bus.ack_esc      = ack_q;
    assign bus.valido_leido = val_q;
    assign bus.ocupado      = ocu_q;
    assign bus.dato_leido   = dato_q;
    assign bus.dir_leido    = dir_q;

    // Access FSM. Strobes and bus drive are registered and updated on the
    // edge that enters each state, so the bus is released on the same edge
    // the strobes rise. In the cycle where ack_esc is high the requester has
    // not yet seen it, so req_esc is ignored there to avoid a repeated burst.
    // A tick arriving on the edge that grants a read merges into that burst.
    always_ff @(posedge reloj or negedge resetM) begin
        if (!resetM) begin
            state   <= IDLE;
            phase   <= '0;
            idx     <= 3'd0;
            is_read <= 1'b0;
            grp     <= 2'd0;
            wdat    <= '0;
            pend    <= 1'b0;
            drv_en  <= 1'b0;
            drv_val <= 8'h00;
            cs_q    <= 1'b1;
            rd_q    <= 1'b1;
            wr_q    <= 1'b1;
            ad_q    <= 1'b1;
            ack_q   <= 1'b0;
            val_q   <= 1'b0;
            ocu_q   <= 1'b0;
            dato_q  <= 8'h00;
            dir_q   <= 8'h00;
        end else begin
            ack_q <= 1'b0;
            val_q <= 1'b0;
            if (bus.tick_lectura) begin
                pend <= 1'b1;
            end

            if (state == IDLE) begin
                phase <= '0;
                idx   <= 3'd0;
                if (bus.req_esc && !ack_q) begin
                    grp  <= bus.grupo_esc;
                    wdat <= {bus.dato_esc2, bus.dato_esc1, bus.dato_esc0};
                    if (bus.grupo_esc == 2'd3) begin
                        ack_q <= 1'b1;
                    end else begin
                        is_read <= 1'b0;
                        state   <= ADDR;
                        ocu_q   <= 1'b1;
                        cs_q    <= 1'b0;
                        wr_q    <= 1'b0;
                        ad_q    <= 1'b0;
                        drv_en  <= 1'b1;
                        drv_val <= acc_addr(1'b0, bus.grupo_esc, 3'd0);
                    end
                end else if (pend || bus.tick_lectura) begin
                    pend    <= 1'b0;
                    is_read <= 1'b1;
                    state   <= ADDR;
                    ocu_q   <= 1'b1;
                    cs_q    <= 1'b0;
                    wr_q    <= 1'b0;
                    ad_q    <= 1'b0;
                    drv_en  <= 1'b1;
                    drv_val <= acc_addr(1'b1, 2'd0, 3'd0);
                end
            end else if (phase != PH_LAST) begin
                phase <= phase + PW'(1);
            end else begin
                phase <= '0;
                case (state)
                    ADDR: begin
                        state  <= GAP1;
                        cs_q   <= 1'b1;
                        rd_q   <= 1'b1;
                        wr_q   <= 1'b1;
                        ad_q   <= 1'b1;
                        drv_en <= 1'b0;
                    end
                    GAP1: begin
                        state <= DATA;
                        cs_q  <= 1'b0;
                        ad_q  <= 1'b1;
                        if (is_read && idx != 3'd0) begin
                            rd_q <= 1'b0;
                        end else begin
                            wr_q    <= 1'b0;
                            drv_en  <= 1'b1;
                            drv_val <= is_read ? 8'h00 : acc_data(idx, wdat);
                        end
                    end
                    DATA: begin
                        state  <= GAP2;
                        cs_q   <= 1'b1;
                        rd_q   <= 1'b1;
                        wr_q   <= 1'b1;
                        drv_en <= 1'b0;
                        if (is_read && idx != 3'd0) begin
                            dato_q <= DIR_DATO;
                            dir_q  <= acc_addr(1'b1, 2'd0, idx);
                            val_q  <= 1'b1;
                        end
                    end
                    GAP2: begin
                        if (idx == (is_read ? 3'd6 : 3'd3)) begin
                            state <= IDLE;
                            ocu_q <= 1'b0;
                            ack_q <= !is_read;
                        end else begin
                            idx     <= idx + 3'd1;
                            state   <= ADDR;
                            cs_q    <= 1'b0;
                            wr_q    <= 1'b0;
                            ad_q    <= 1'b0;
                            drv_en  <= 1'b1;
                            drv_val <= acc_addr(is_read, grp, idx + 3'd1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rtc_bus_scheduler.sv
// ---------------------------------------------------------------------------
// tb_rtc_bus_scheduler
//
// Self-checking bench for rtc_bus_scheduler with T_PH = 2. An RTC model
// answers reads with address + 0x10 and a bus holder drives 0x00 whenever
// CS is high, so any late release of DIR_DATO shows up as a corrupted value.
// A monitor turns the strobes into a list of accesses, read-back bytes,
// burst lengths and idle gaps; the expected lists come from the burst
// definitions (addresses, commands and bytes) and plain arithmetic.
// ---------------------------------------------------------------------------
module tb_rtc_bus_scheduler;

    localparam int TPH = 2;

    logic reloj = 1'b0;
    logic resetM;

    rtc_bus_scheduler_if bif();
    wire  [7:0] dir_dato;
    logic [7:0] rtc_addr = 8'h00;

    // Bus holder while deselected, RTC answers during its read data phase.
    assign dir_dato = bif.CS ? 8'h00 : (!bif.RD ? (rtc_addr + 8'h10) : 8'hzz);

    rtc_bus_scheduler #(.T_PH(TPH)) dut (
        .reloj    (reloj),
        .resetM   (resetM),
        .bus      (bif),
        .DIR_DATO (dir_dato)
    );

    initial begin
        forever #5 reloj = ~reloj;
    end

    int checks = 0;
    int errors = 0;

    // Expected and observed records. An access is {is_write, addr, data}.
    logic [16:0] exp_acc[$];
    logic [15:0] exp_rd[$];
    int          exp_busy[$];
    int          exp_gap[$];
    int          exp_acks;

    logic [16:0] obs_acc[$];
    logic [15:0] obs_rd[$];
    int          obs_busy[$];
    int          obs_gap[$];
    bit          obs_ack_fell[$];
    int          strobe_act;
    bit          phase_err;
    bit          bus_err;
    bit          have_fall;
    int          cycle = 0;

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bus monitor: samples on the falling edge, away from the active edge.
    initial begin : monitor
        logic [4:0]  prev_sig;
        logic [4:0]  sig;
        logic [16:0] cur;
        int          run_len;
        int          busy_len;
        int          last_fall;
        bit          in_addr;
        bit          in_data;
        bit          prev_ocu;
        prev_sig  = 5'b01111;
        cur       = '0;
        run_len   = 0;
        busy_len  = 0;
        last_fall = 0;
        in_addr   = 1'b0;
        in_data   = 1'b0;
        prev_ocu  = 1'b0;
        forever begin
            @(negedge reloj);
            cycle++;
            if (!resetM) begin
                prev_sig = 5'b01111;
                run_len  = 0;
                busy_len = 0;
                in_addr  = 1'b0;
                in_data  = 1'b0;
                prev_ocu = 1'b0;
                have_fall = 1'b0;
            end else begin
                sig = {bif.ocupado, bif.CS, bif.RD, bif.WR, bif.A_D};
                if (sig[3:0] != 4'b1111) strobe_act++;
                if (!bif.RD && !bif.WR) bus_err = 1'b1;
                if (bif.CS && dir_dato !== 8'h00) bus_err = 1'b1;
                if (!bif.CS && !bif.A_D) begin
                    if (!in_addr) begin
                        cur[15:8] = dir_dato;
                        cur[7:0]  = 8'h00;
                        rtc_addr  = dir_dato;
                    end
                    in_addr = 1'b1;
                end else begin
                    in_addr = 1'b0;
                end
                if (!bif.CS && bif.A_D) begin
                    in_data = 1'b1;
                    cur[16] = !bif.WR;
                    if (!bif.WR) cur[7:0] = dir_dato;
                    if (!bif.RD && dir_dato !== rtc_addr + 8'h10) bus_err = 1'b1;
                end else if (in_data) begin
                    obs_acc.push_back(cur);
                    in_data = 1'b0;
                end
                if (sig == prev_sig) begin
                    run_len++;
                end else begin
                    if (prev_sig[4] && run_len != TPH) phase_err = 1'b1;
                    prev_sig = sig;
                    run_len  = 1;
                end
                if (bif.ocupado) begin
                    if (!prev_ocu && have_fall) obs_gap.push_back(cycle - last_fall);
                    busy_len++;
                end else if (prev_ocu) begin
                    obs_busy.push_back(busy_len);
                    busy_len  = 0;
                    have_fall = 1'b1;
                    last_fall = cycle;
                end
                if (bif.ack_esc) obs_ack_fell.push_back(prev_ocu && !bif.ocupado);
                if (bif.valido_leido) obs_rd.push_back({bif.dir_leido, bif.dato_leido});
                prev_ocu = bif.ocupado;
            end
        end
    end

    initial begin : watchdog
        #(60000 * 10);
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic clear_obs();
        exp_acc.delete();
        exp_rd.delete();
        exp_busy.delete();
        exp_gap.delete();
        exp_acks = 0;
        obs_acc.delete();
        obs_rd.delete();
        obs_busy.delete();
        obs_gap.delete();
        obs_ack_fell.delete();
        strobe_act = 0;
        phase_err  = 1'b0;
        bus_err    = 1'b0;
        have_fall  = 1'b0;
    endtask

    // Reference bursts built from the RTC address map.
    task automatic model_read();
        exp_acc.push_back({1'b1, 8'hF0, 8'h00});
        for (int a = 8'h21; a <= 8'h26; a++) begin
            exp_acc.push_back({1'b0, 8'(a), 8'h00});
            exp_rd.push_back({8'(a), 8'(a + 16)});
        end
        exp_busy.push_back(28 * TPH);
    endtask

    task automatic model_write(input int g, input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
        int base;
        logic [7:0] d [3];
        base = (g == 0) ? 'h21 : ((g == 1) ? 'h24 : 'h41);
        d[0] = d0;
        d[1] = d1;
        d[2] = d2;
        for (int i = 0; i < 3; i++) exp_acc.push_back({1'b1, 8'(base + i), d[i]});
        exp_acc.push_back({1'b1, 8'hF1, 8'h00});
        exp_busy.push_back(16 * TPH);
        exp_acks++;
    endtask

    task automatic check_scenario(input string tag, input bit ack_after_burst);
        check_output({tag, " access count"}, 32'(obs_acc.size()), 32'(exp_acc.size()));
        for (int i = 0; i < obs_acc.size() && i < exp_acc.size(); i++)
            check_output($sformatf("%s access%0d", tag, i), 32'(obs_acc[i]), 32'(exp_acc[i]));
        check_output({tag, " read count"}, 32'(obs_rd.size()), 32'(exp_rd.size()));
        for (int i = 0; i < obs_rd.size() && i < exp_rd.size(); i++)
            check_output($sformatf("%s read%0d", tag, i), 32'(obs_rd[i]), 32'(exp_rd[i]));
        check_output({tag, " burst count"}, 32'(obs_busy.size()), 32'(exp_busy.size()));
        for (int i = 0; i < obs_busy.size() && i < exp_busy.size(); i++)
            check_output($sformatf("%s burst%0d length", tag, i), 32'(obs_busy[i]), 32'(exp_busy[i]));
        check_output({tag, " gap count"}, 32'(obs_gap.size()), 32'(exp_gap.size()));
        for (int i = 0; i < obs_gap.size() && i < exp_gap.size(); i++)
            check_output($sformatf("%s gap%0d", tag, i), 32'(obs_gap[i]), 32'(exp_gap[i]));
        check_output({tag, " ack count"}, 32'(obs_ack_fell.size()), 32'(exp_acks));
        foreach (obs_ack_fell[i])
            check_output($sformatf("%s ack%0d timing", tag, i), 32'(obs_ack_fell[i]), 32'(ack_after_burst));
        check_output({tag, " phase length"}, 32'(phase_err), 32'd0);
        check_output({tag, " bus drive"}, 32'(bus_err), 32'd0);
        clear_obs();
    endtask

    // Drives a read tick and/or a write request, then checks the grant.
    task automatic apply_stimulus(input string tag, input bit do_tick, input bit do_req,
                                  input logic [1:0] g, input logic [7:0] d0,
                                  input logic [7:0] d1, input logic [7:0] d2);
        @(posedge reloj);
        #1;
        bif.tick_lectura = do_tick;
        if (do_req) begin
            bif.req_esc   = 1'b1;
            bif.grupo_esc = g;
            bif.dato_esc0 = d0;
            bif.dato_esc1 = d1;
            bif.dato_esc2 = d2;
        end
        @(posedge reloj);
        #1;
        bif.tick_lectura = 1'b0;
        @(negedge reloj);
        if (do_req && g == 2'd3) begin
            check_output({tag, " invalid ack"}, 32'(bif.ack_esc), 32'd1);
            check_output({tag, " invalid CS"}, 32'(bif.CS), 32'd1);
        end else begin
            check_output({tag, " grant CS"}, 32'(bif.CS), 32'd0);
            check_output({tag, " grant ocupado"}, 32'(bif.ocupado), 32'd1);
        end
        if (do_req) begin
            bif.grupo_esc = 2'($urandom_range(0, 3));
            bif.dato_esc0 = 8'($urandom);
            bif.dato_esc1 = 8'($urandom);
            bif.dato_esc2 = 8'($urandom);
        end
    endtask

    task automatic pulse_tick();
        @(posedge reloj);
        #1;
        bif.tick_lectura = 1'b1;
        @(posedge reloj);
        #1;
        bif.tick_lectura = 1'b0;
    endtask

    task automatic wait_ack_drop(input string tag);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 600 && !seen; n++) begin
            @(negedge reloj);
            if (bif.ack_esc) seen = 1'b1;
        end
        check_output({tag, " ack seen"}, 32'(seen), 32'd1);
        @(posedge reloj);
        #1;
        bif.req_esc = 1'b0;
    endtask

    task automatic wait_quiet(input string tag);
        int quiet;
        quiet = 0;
        for (int n = 0; n < 2000 && quiet < 4; n++) begin
            @(negedge reloj);
            if (bif.ocupado) quiet = 0;
            else quiet++;
        end
        check_output({tag, " settle"}, 32'(quiet >= 4), 32'd1);
    endtask

    initial begin : main
        logic [7:0] d0;
        logic [7:0] d1;
        logic [7:0] d2;
        int         g;
        bit         hit;

        resetM           = 1'b0;
        bif.tick_lectura = 1'b0;
        bif.req_esc      = 1'b0;
        bif.grupo_esc    = 2'd0;
        bif.dato_esc0    = 8'h00;
        bif.dato_esc1    = 8'h00;
        bif.dato_esc2    = 8'h00;
        clear_obs();

        // Reset state.
        repeat (3) @(negedge reloj);
        check_output("reset strobes", 32'({bif.CS, bif.RD, bif.WR, bif.A_D}), 32'hF);
        check_output("reset ocupado", 32'(bif.ocupado), 32'd0);
        check_output("reset ack/valido", 32'({bif.ack_esc, bif.valido_leido}), 32'd0);
        check_output("reset read regs", 32'({bif.dir_leido, bif.dato_leido}), 32'd0);
        check_output("reset bus", 32'(dir_dato), 32'd0);
        @(posedge reloj);
        #1;
        resetM = 1'b1;
        clear_obs();
        repeat (1000) @(negedge reloj);
        check_output("idle strobe activity", 32'(strobe_act), 32'd0);
        check_scenario("idle", 1'b0);

        // Single read burst.
        $display("[TB] read burst");
        apply_stimulus("read", 1'b1, 1'b0, 2'd0, 8'h00, 8'h00, 8'h00);
        model_read();
        wait_quiet("read");
        check_scenario("read", 1'b1);

        // Write hora with fixed bytes; inputs scrambled after grant.
        $display("[TB] write hora");
        apply_stimulus("hora", 1'b0, 1'b1, 2'd0, 8'h45, 8'h30, 8'h12);
        model_write(0, 8'h45, 8'h30, 8'h12);
        wait_ack_drop("hora");
        wait_quiet("hora");
        check_scenario("hora", 1'b1);

        // Simultaneous tick and fecha write: write first, then the read.
        $display("[TB] simultaneous requests");
        d0 = 8'($urandom); d1 = 8'($urandom); d2 = 8'($urandom);
        apply_stimulus("simul", 1'b1, 1'b1, 2'd1, d0, d1, d2);
        model_write(1, d0, d1, d2);
        model_read();
        exp_gap.push_back(1);
        wait_ack_drop("simul");
        wait_quiet("simul");
        check_scenario("simul", 1'b1);

        // Three ticks during a crono write merge into one read burst.
        $display("[TB] merged ticks");
        d0 = 8'($urandom); d1 = 8'($urandom); d2 = 8'($urandom);
        apply_stimulus("merge", 1'b0, 1'b1, 2'd2, d0, d1, d2);
        model_write(2, d0, d1, d2);
        for (int k = 0; k < 3; k++) begin
            repeat ($urandom_range(1, 6)) @(posedge reloj);
            pulse_tick();
        end
        model_read();
        exp_gap.push_back(1);
        wait_ack_drop("merge");
        wait_quiet("merge");
        check_scenario("merge", 1'b1);

        // Invalid group: ack the cycle after grant, no bus activity.
        $display("[TB] invalid group");
        apply_stimulus("grp3", 1'b0, 1'b1, 2'd3, 8'hAA, 8'hBB, 8'hCC);
        @(posedge reloj);
        #1;
        bif.req_esc = 1'b0;
        exp_acks = 1;
        repeat (10) @(negedge reloj);
        check_output("grp3 strobe activity", 32'(strobe_act), 32'd0);
        check_scenario("grp3", 1'b0);

        // Randomized mix of bursts.
        $display("[TB] random bursts");
        for (int it = 0; it < 6; it++) begin
            repeat ($urandom_range(0, 20)) @(posedge reloj);
            if ($urandom_range(0, 1) == 1) begin
                g  = $urandom_range(0, 2);
                d0 = 8'($urandom); d1 = 8'($urandom); d2 = 8'($urandom);
                apply_stimulus($sformatf("rnd%0d", it), 1'b0, 1'b1, 2'(g), d0, d1, d2);
                model_write(g, d0, d1, d2);
                wait_ack_drop($sformatf("rnd%0d", it));
            end else begin
                apply_stimulus($sformatf("rnd%0d", it), 1'b1, 1'b0, 2'd0, 8'h00, 8'h00, 8'h00);
                model_read();
            end
            wait_quiet($sformatf("rnd%0d", it));
            check_scenario($sformatf("rnd%0d", it), 1'b1);
        end

        // Reset during the data phase of the third read access.
        $display("[TB] reset mid-burst");
        apply_stimulus("midrst", 1'b1, 1'b0, 2'd0, 8'h00, 8'h00, 8'h00);
        hit = 1'b0;
        for (int n = 0; n < 200 && !hit; n++) begin
            @(negedge reloj);
            if (obs_acc.size() == 3 && !bif.RD) hit = 1'b1;
        end
        check_output("midrst reached read data", 32'(hit), 32'd1);
        #2;
        resetM = 1'b0;
        #1;
        check_output("midrst strobes", 32'({bif.CS, bif.RD, bif.WR, bif.A_D}), 32'hF);
        check_output("midrst ocupado", 32'(bif.ocupado), 32'd0);
        check_output("midrst read regs", 32'({bif.dir_leido, bif.dato_leido}), 32'd0);
        repeat (3) @(negedge reloj);
        @(posedge reloj);
        #1;
        resetM = 1'b1;
        repeat (10) @(negedge reloj);
        exp_acc.push_back({1'b1, 8'hF0, 8'h00});
        exp_acc.push_back({1'b0, 8'h21, 8'h00});
        exp_acc.push_back({1'b0, 8'h22, 8'h00});
        exp_rd.push_back(16'h2131);
        exp_rd.push_back(16'h2232);
        check_scenario("midrst", 1'b1);

        apply_stimulus("postrst", 1'b1, 1'b0, 2'd0, 8'h00, 8'h00, 8'h00);
        model_read();
        wait_quiet("postrst");
        check_scenario("postrst", 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
